// File: rtl/sample_pacer.sv
// Purpose : buffers incoming samples and releases one per sample period at a steady rate.
// Latency : outData/outStrobe update one cycle after the internal rate tick.
// Backpres: none upstream; a sample arriving on a full buffer is dropped and flags overflow.
//
// Ports:
//   clk, reset (sync, active-low), enable (low = idle + flush)
//   inAvailable/inData : one-cycle sample strobe with data
//   outData/outStrobe  : current output sample and its one-cycle update pulse
//   running            : high while playing
//   level              : buffer occupancy, 0..fifoDepth
//   overflow           : sticky drop flag
//   underruns          : saturating count of empty-buffer ticks while playing
module sample_pacer #(
    parameter int clockRate  = 76_800_000,
    parameter int sampleRate = 48_000,
    parameter int sampleBits = 24,
    parameter int fifoDepth  = 16,
    parameter int primeLevel = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        inAvailable,
    input  logic [sampleBits-1:0]       inData,
    output logic [sampleBits-1:0]       outData,
    output logic                        outStrobe,
    output logic                        running,
    output logic [$clog2(fifoDepth):0]  level,
    output logic                        overflow,
    output logic [7:0]                  underruns
);

    localparam int divisor = clockRate / sampleRate;
    localparam int cnt_w   = $clog2(divisor);
    localparam int ptr_w   = $clog2(fifoDepth);

    localparam logic [cnt_w-1:0]      tick_last  = cnt_w'(divisor - 1);
    localparam logic [cnt_w-1:0]      cnt_one    = cnt_w'(1);
    localparam logic [ptr_w-1:0]      ptr_one    = ptr_w'(1);
    localparam logic [ptr_w:0]        lvl_one    = (ptr_w + 1)'(1);
    localparam logic [ptr_w:0]        full_level = (ptr_w + 1)'(fifoDepth);
    localparam logic [ptr_w:0]        prime_mark = (ptr_w + 1)'(primeLevel);
    localparam logic [sampleBits-1:0] midscale   = {1'b1, {(sampleBits - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t                 state;
    logic [cnt_w-1:0]       tick_cnt;
    logic [ptr_w-1:0]       wr_ptr;
    logic [ptr_w-1:0]       rd_ptr;
    logic [sampleBits-1:0]  mem [fifoDepth];

    logic tick;
    logic full;
    logic empty;
    logic accept;
    logic do_pop;
    logic do_under;
    logic do_push;
    logic do_drop;

    assign tick     = (tick_cnt == tick_last);
    assign full     = (level == full_level);
    assign empty    = (level == '0);

    // Writes are only meaningful once playback is enabled and out of IDLE;
    // a disable in the same cycle wins over any push or pop.
    assign accept   = enable && (state != IDLE);
    assign do_pop   = enable && (state == PLAY) && tick && !empty;
    assign do_under = enable && (state == PLAY) && tick && empty;
    // A full buffer still takes a sample when the head leaves in the same cycle;
    // the pop reads the pre-push head so there is no bypass path.
    assign do_push  = accept && inAvailable && (!full || do_pop);
    assign do_drop  = accept && inAvailable && full && !do_pop;

    assign running  = (state == PLAY);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= inData;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            outData   <= midscale;
            outStrobe <= 1'b0;
            overflow  <= 1'b0;
            underruns <= '0;
        end else begin
            // The rate counter free-runs regardless of playback state.
            tick_cnt  <= tick ? '0 : tick_cnt + cnt_one;
            outStrobe <= 1'b0;

            if (!enable) begin
                state   <= IDLE;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level   <= '0;
                outData <= midscale;
            end else begin
                case (state)
                    IDLE: begin
                        state <= PRIME;
                    end
                    PRIME: begin
                        if (level >= prime_mark) begin
                            state <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (do_under) begin
                            // Emit silence and refill before playing again.
                            state     <= PRIME;
                            outData   <= midscale;
                            outStrobe <= 1'b1;
                            if (underruns != 8'hFF) begin
                                underruns <= underruns + 8'd1;
                            end
                        end else if (do_pop) begin
                            outData   <= mem[rd_ptr];
                            outStrobe <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase

                if (do_push) begin
                    wr_ptr <= wr_ptr + ptr_one;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + ptr_one;
                end
                if (do_push && !do_pop) begin
                    level <= level + lvl_one;
                end else if (!do_push && do_pop) begin
                    level <= level - lvl_one;
                end
                if (do_drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
